electron_clken_gen: RTL

//  Consumer of the system PLL: runs on the 16 MHz PLL output with the PLL lock flag, and issues system reset plus all

---
 rtl/electron_clk_pkg.sv | 29 ++
 rtl/electron_sync_bit.sv | 25 ++
 rtl/electron_clken_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/electron_clk_pkg.sv
// -----------------------------------------------------------------------------
// electron_clk_pkg
// Shared types and constants for the Electron clock-enable generator.
//   top_state_e : system bring-up FSM (RESET -> HOLD -> RUN)
//   cpu_state_e : CPU cycle-stretch FSM (FAST / SLOW_WAIT / CONTEND)
//   DIV_W       : width of the 16 MHz phase divider
//   DIV_*       : divider decode values for the strobes / CPU decision points
// -----------------------------------------------------------------------------
package electron_clk_pkg;

  localparam int unsigned DIV_W = 4;

  localparam logic [1:0] DIV_4M = 2'd3;
  localparam logic [2:0] DIV_2M = 3'd7;
  localparam logic [3:0] DIV_1M = 4'd15;

  typedef enum logic [1:0] {
    RESET,
    HOLD,
    RUN
  } top_state_e;

  typedef enum logic [1:0] {
    FAST,
    SLOW_WAIT,
    CONTEND
  } cpu_state_e;

endpackage : electron_clk_pkg

// File: rtl/electron_sync_bit.sv
// -----------------------------------------------------------------------------
// electron_sync_bit
// Reset-free multi-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i : destination clock
//   d_i   : asynchronous input level
//   q_o   : synchronized level, STAGES clocks of latency
// -----------------------------------------------------------------------------
module electron_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule : electron_sync_bit

// File: rtl/electron_clken_gen.sv
// -----------------------------------------------------------------------------
// electron_clken_gen
// Runs on the 16 MHz PLL clock, sequences system reset from the PLL lock flag
// and produces the Electron clock enables.
// Optional feature: define ELECTRON_TURBO_EN to allow 4 MHz CPU fast cycles
// (extra CPU decision points at div=3/11 when turbo=1). Without it the turbo
// port is present but ignored.
// Ports:
//   clk_sys     : 16 MHz system clock
//   rst         : synchronous active-high reset
//   pll_locked  : PLL lock, asynchronous to clk_sys
//   cpu_slow    : current CPU cycle targets RAM / 1 MHz space
//   contend     : ULA owns RAM
//   turbo       : request 4 MHz CPU fast cycles
//   sys_reset   : reset to the rest of the core (high until RUN)
//   clken_8m/4m/2m/1m : 1-of-2/4/8/16 registered strobes
//   cpu_clken   : CPU phase-advance strobe
//   cpu_stretch : high while the CPU cycle is stretched/stalled
// -----------------------------------------------------------------------------
module electron_clken_gen
  import electron_clk_pkg::*;
#(
  parameter int unsigned RST_HOLD    = 1024,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic pll_locked,
  input  logic cpu_slow,
  input  logic contend,
  input  logic turbo,
  output logic sys_reset,
  output logic clken_8m,
  output logic clken_4m,
  output logic clken_2m,
  output logic clken_1m,
  output logic cpu_clken,
  output logic cpu_stretch
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  logic lock_s;

  electron_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i(clk_sys),
    .d_i  (pll_locked),
    .q_o  (lock_s)
  );

  // ---------------------------------------------------------------------------
  // Top FSM
  // ---------------------------------------------------------------------------
  top_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              run_q, run_d;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= RESET;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rst || !lock_s) begin
      state_d = RESET;
    end else begin
      unique case (state_q)
        RESET:   state_d = HOLD;
        HOLD:    if (hold_q == HOLD_LAST) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = RESET;
      endcase
    end
  end

  // Counter restarts from zero on every HOLD entry.
  assign hold_d = (state_q == HOLD) ? hold_q + HOLD_W'(1) : '0;

  assign run_q     = (state_q == RUN);
  assign run_d     = (state_d == RUN);
  assign sys_reset = !run_q;

  // ---------------------------------------------------------------------------
  // Phase divider and registered strobes. Strobes are computed from the next
  // divider value so each one is high in the same cycle the divider shows it.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;

  assign div_d = (run_q && run_d) ? div_q + DIV_W'(1) : '0;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      div_q    <= '0;
      clken_8m <= 1'b0;
      clken_4m <= 1'b0;
      clken_2m <= 1'b0;
      clken_1m <= 1'b0;
    end else begin
      div_q    <= div_d;
      clken_8m <= run_d && div_d[0];
      clken_4m <= run_d && (div_d[1:0] == DIV_4M);
      clken_2m <= run_d && (div_d[2:0] == DIV_2M);
      clken_1m <= run_d && (div_d == DIV_1M);
    end
  end

  // ---------------------------------------------------------------------------
  // CPU FSM. Decisions use the inputs present during the decision cycle, so
  // cpu_clken is a Mealy output of the current state, divider and inputs.
  // ---------------------------------------------------------------------------
  cpu_state_e cpu_q, cpu_d;
  logic       cpu_fire;
  logic       dp_1m, dp_2m, dp_4m;

  assign dp_1m = (div_q == DIV_1M);
  assign dp_2m = (div_q == {1'b0, DIV_2M});

`ifdef ELECTRON_TURBO_EN
  assign dp_4m = turbo && (div_q[2:0] == {1'b0, DIV_4M});
`else
  logic unused_turbo;
  assign unused_turbo = turbo;
  assign dp_4m        = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cpu_q <= FAST;
    end else begin
      cpu_q <= cpu_d;
    end
  end

  always_comb begin
    cpu_d    = cpu_q;
    cpu_fire = 1'b0;
    if (run_q) begin
      unique case (cpu_q)
        FAST: begin
          if (dp_1m) begin
            if (cpu_slow && contend) cpu_d = CONTEND;
            else                     cpu_fire = 1'b1;
          end else if (dp_2m || dp_4m) begin
            if (cpu_slow) cpu_d = SLOW_WAIT;
            else          cpu_fire = 1'b1;
          end
        end
        SLOW_WAIT: begin
          if (dp_1m) begin
            if (contend) begin
              cpu_d = CONTEND;
            end else begin
              cpu_d    = FAST;
              cpu_fire = 1'b1;
            end
          end
        end
        CONTEND: begin
          if (dp_1m && !contend) begin
            cpu_d    = FAST;
            cpu_fire = 1'b1;
          end
        end
        default: cpu_d = FAST;
      endcase
    end
    // Leaving RUN abandons any stretch in progress.
    if (!run_d) cpu_d = FAST;
  end

  always_comb begin
    cpu_clken   = cpu_fire && run_q && !rst;
    cpu_stretch = (cpu_q != FAST);
  end

endmodule : electron_clken_gen
